// File: rtl/accel_mem_arbiter.sv
// Shared data RAM behind accelerator and CPU ports; accelerator has fixed priority.
// Build option MEMARB_STATS_EN adds saturating access/stall counters.
module accel_mem_arbiter #(
  parameter int DEPTH_LOG2   = 10,
  parameter int STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_valid,
  input  logic        acc_write,
  input  logic [18:0] acc_addr,
  input  logic [18:0] acc_wdata,
  output logic [18:0] acc_rdata,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [18:0] cpu_addr,
  input  logic [18:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [18:0] cpu_rdata,
  input  logic        err_clr,
  output logic        range_err,
  output logic        starve_err,
  output logic [15:0] acc_cnt,
  output logic [15:0] stall_cnt
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  logic [18:0] mem_q [DEPTH];

  logic                  acc_in_range, cpu_in_range;
  logic [DEPTH_LOG2-1:0] acc_idx, cpu_idx;
  logic                  cpu_accept, cpu_stall;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_widx;
  logic [18:0]           mem_wdat;

  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic [18:0] cpu_rdata_q, cpu_rdata_d;
  logic        range_err_q, range_err_d;
  logic        starve_err_q, starve_err_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;

  always_comb begin
    acc_in_range = ((acc_addr >> DEPTH_LOG2) == 19'd0);
    cpu_in_range = ((cpu_addr >> DEPTH_LOG2) == 19'd0);
    acc_idx      = acc_addr[DEPTH_LOG2-1:0];
    cpu_idx      = cpu_addr[DEPTH_LOG2-1:0];
    cpu_ready    = cpu_req && !acc_valid;
    cpu_accept   = cpu_req && cpu_ready;
    cpu_stall    = cpu_req && !cpu_ready;

    acc_rdata = 19'd0;
    if (acc_valid && !acc_write && acc_in_range) begin
      acc_rdata = mem_q[acc_idx];
    end

    // At most one port can write per cycle because the CPU is blocked under acc_valid.
    mem_we   = 1'b0;
    mem_widx = acc_idx;
    mem_wdat = acc_wdata;
    if (acc_valid && acc_write && acc_in_range) begin
      mem_we = rst_n;
    end else if (cpu_accept && cpu_write && cpu_in_range) begin
      mem_we   = rst_n;
      mem_widx = cpu_idx;
      mem_wdat = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdat;
    end
  end

  always_comb begin
    cpu_rvalid_d = cpu_accept && !cpu_write;
    cpu_rdata_d  = cpu_rdata_q;
    if (cpu_accept && !cpu_write) begin
      cpu_rdata_d = cpu_in_range ? mem_q[cpu_idx] : 19'd0;
    end

    starve_cnt_d = 8'd0;
    if (cpu_stall) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_LIM8) ? STARVE_LIM8 : starve_cnt_q + 8'd1;
    end

    // Clear first so a same-cycle set condition overrides it.
    range_err_d  = range_err_q && !err_clr;
    starve_err_d = starve_err_q && !err_clr;
    if ((acc_valid && !acc_in_range) || (cpu_accept && !cpu_in_range)) begin
      range_err_d = 1'b1;
    end
    if (cpu_stall && (starve_cnt_d == STARVE_LIM8)) begin
      starve_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 19'd0;
      range_err_q  <= 1'b0;
      starve_err_q <= 1'b0;
      starve_cnt_q <= 8'd0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      range_err_q  <= range_err_d;
      starve_err_q <= starve_err_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign range_err  = range_err_q;
  assign starve_err = starve_err_q;

`ifdef MEMARB_STATS_EN
  logic [15:0] acc_cnt_q, acc_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (err_clr) begin
      acc_cnt_d   = 16'd0;
      stall_cnt_d = 16'd0;
    end else begin
      if (acc_valid && (acc_cnt_q != 16'hFFFF)) begin
        acc_cnt_d = acc_cnt_q + 16'd1;
      end
      if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt_q   <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign acc_cnt   = acc_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign acc_cnt   = 16'd0;
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/accel_mem_arbiter.md
# accel_mem_arbiter

Shared data-memory stage sitting directly downstream of the crypto accelerator's memory master port and the CPU's data port. Holds the on-chip data RAM. Arbitrates the two masters with fixed accelerator priority, because the accelerator has no backpressure and samples read data in the same cycle it asserts its request. Also provides sticky error flags and optional access statistics.

## Interface
- `DEPTH_LOG2`, 10 — RAM holds 2^DEPTH_LOG2 words of 19 bits.
- `STARVE_LIMIT`, 64 — consecutive CPU stall cycles that raise `starve_err`; legal range 1..255.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset; synchronous, active-low.
- `acc_valid` in 1 — accelerator request, always granted.
- `acc_write` in 1 — 1 = write, 0 = read.
- `acc_addr` in 19 — word address.
- `acc_wdata` in 19 — write data.
- `acc_rdata` out 19 — combinational read data.
- `cpu_req` in 1 — CPU request valid.
- `cpu_write` in 1 — 1 = write.
- `cpu_addr` in 19 — word address.
- `cpu_wdata` in 19 — write data.
- `cpu_ready` out 1 — combinational accept, `cpu_req && !acc_valid`.
- `cpu_rvalid` out 1 — registered read-data strobe.
- `cpu_rdata` out 19 — registered read data.
- `err_clr` in 1 — single-cycle clear of the sticky flags.
- `range_err` out 1 — sticky out-of-range access flag.
- `starve_err` out 1 — sticky CPU starvation flag.
- `acc_cnt` out 16 — accelerator access count (stats).
- `stall_cnt` out 16 — CPU stall-cycle count (stats).

## Operation
- In range means address bits [18:DEPTH_LOG2] are all zero; the RAM index is `addr[DEPTH_LOG2-1:0]`.
- **Accelerator port**
  - Read: `acc_rdata` = RAM[index] combinationally in the same cycle.
  - `acc_rdata` = 0 when `acc_valid`=0, `acc_write`=1, or the address is out of range.
  - Write: RAM updates at the clock edge that ends the cycle.
- **CPU port**
  - Accepted on any edge where `cpu_req && cpu_ready`.
  - Accepted write: updates RAM.
  - Accepted read: captures the pre-edge RAM contents into `cpu_rdata` and pulses `cpu_rvalid` for one cycle.
  - Back-to-back accepts are legal; one response is issued per accepted read.
  - `cpu_rdata` holds its value between responses.
- **Ordering**
  - Both ports never write in the same cycle, since the CPU is blocked whenever `acc_valid`=1.
  - Read-after-write to the same address in the next cycle returns the new data.
- **Out-of-range access** (any accepted or accelerator request):
  - Writes are dropped.
  - Reads return 0; the CPU still gets `cpu_rvalid`.
  - `range_err` is set.
- **Starvation counter** (8-bit)
  - Increments each cycle `cpu_req && !cpu_ready`.
  - Clears on accept or when `cpu_req`=0.
  - Reaching STARVE_LIMIT sets `starve_err`; the counter saturates there.
- **Sticky flags**
  - `err_clr` clears both flags.
  - If a set condition occurs in the same cycle as `err_clr`, the set wins.
- RAM contents are not reset.

## Timing
- Reset values: `cpu_rvalid`=0, `cpu_rdata`=0, `range_err`=0, `starve_err`=0, `acc_cnt`=0, `stall_cnt`=0, starvation counter=0.
- Combinational outputs (`acc_rdata`, `cpu_ready`) follow their inputs during reset.
- Writes are suppressed while `rst_n`=0.
- Accelerator read latency: 0 cycles (same cycle). Write takes effect at the end of the request cycle.
- CPU read latency: accept at edge N, then `cpu_rvalid`=1 during cycle N+1.
- Reset asserted mid-operation: any pending `cpu_rvalid` is dropped on the next edge and no response is issued for it.

## Configuration
- `MEMARB_STATS_EN` defined:
  - `acc_cnt` increments on every cycle with `acc_valid`=1.
  - `stall_cnt` increments on every cycle with `cpu_req && !cpu_ready`.
  - Both are 16-bit, saturating at 16'hFFFF, and cleared by reset and by `err_clr`.
- Not defined: `acc_cnt` and `stall_cnt` are tied to 0 and no counter logic is synthesized. Ports are present in both builds.

## Test plan
- **Accelerator write then read**
  - Stimulus: accelerator writes 19'h0ABCD to address 5; next cycle reads address 5.
  - Required: `acc_rdata`=19'h0ABCD in the read cycle.
- **Collision**
  - Stimulus: CPU read of address 5 asserted in the same cycle as an accelerator write.
  - Required: `cpu_ready`=0 that cycle; accept occurs next cycle; `cpu_rvalid`=1 one cycle later with `cpu_rdata`=19'h0ABCD.
- **Out-of-range CPU write**
  - Stimulus: CPU write to address 19'h00400 with DEPTH_LOG2=10.
  - Required: RAM[0] unchanged; `range_err`=1; after `err_clr`, `range_err`=0.
- **Starvation**
  - Stimulus: `acc_valid` held high 64 cycles with `cpu_req` high, STARVE_LIMIT=64.
  - Required: `starve_err` rises after 64 stall cycles; `err_clr` in the same cycle as a new stall at the limit leaves it 1.
- **Reset mid-operation**
  - Stimulus: CPU read accepted, then `rst_n` pulled low on the next cycle.
  - Required: `cpu_rvalid`=0 after that edge; all flags 0.
- **Statistics** (`MEMARB_STATS_EN` defined)
  - Stimulus: 3 accelerator accesses and 2 CPU stall cycles.
  - Required: `acc_cnt`=3, `stall_cnt`=2.
  - Without the macro, both read 0.
